// File: rtl/okeysched.sv
// okeysched: AES-128 round-key streamer feeding a one-round-per-cycle cipher.
// Decrypt expands forward to rk10, then walks the inverse schedule back to rk0.
module okeysched (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         dir,
  input  logic [127:0] key,
  output logic [127:0] roundKey,
  output logic         cstart,
  output logic         kvalid,
  output logic         done,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, PRIME, EXPAND, STREAM} state_t;
  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};
  localparam logic [7:0] RCON [16] = '{8'h00,8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,
                                       8'h80,8'h1b,8'h36,8'h00,8'h00,8'h00,8'h00,8'h00};
  state_t       state_q;
  logic [127:0] key_q, key_d;
  logic [3:0]   cnt_q, ridx;
  logic         dir_q, cstart_q, kvalid_q, done_q, inv;
  logic [31:0]  w0, w1, w2, w3, sub_in, rot, sub, n0;
  // The single SubWord serves both directions: inverse feeds it w3^w2 (the recovered w3 of rk(i-1)).
  always_comb begin
    inv = dir_q && state_q == STREAM;
    ridx = inv ? cnt_q : cnt_q + 4'd1;
    {w0, w1, w2, w3} = key_q;
    sub_in = inv ? w3 ^ w2 : w3;
    rot = {sub_in[23:0], sub_in[31:24]};
    sub = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
    n0 = w0 ^ sub ^ {RCON[ridx], 24'h0};
    key_d = inv ? {n0, w1 ^ w0, w2 ^ w1, w3 ^ w2} : {n0, w1 ^ n0, w2 ^ w1 ^ n0, w3 ^ w2 ^ w1 ^ n0};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      key_q <= '0;
      cnt_q <= '0;
      dir_q <= 1'b0;
      cstart_q <= 1'b0;
      kvalid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          key_q <= key;
          dir_q <= dir;
          cnt_q <= '0;
          cstart_q <= !dir;
          state_q <= dir ? EXPAND : PRIME;
        end
        PRIME: begin
          cstart_q <= 1'b0;
          kvalid_q <= 1'b1;
          state_q <= STREAM;
        end
        EXPAND: begin
          key_q <= key_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd9) begin
            cstart_q <= 1'b1;
            kvalid_q <= 1'b1;
            state_q <= STREAM;
          end
        end
        STREAM: begin
          cstart_q <= 1'b0;
          if (done_q) begin
            kvalid_q <= 1'b0;
            done_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            key_q <= key_d;
            cnt_q <= dir_q ? cnt_q - 4'd1 : cnt_q + 4'd1;
            done_q <= dir_q ? cnt_q == 4'd1 : cnt_q == 4'd9;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign roundKey = key_q;
  assign cstart = cstart_q;
  assign kvalid = kvalid_q;
  assign done = done_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_okeysched.sv
// tb_okeysched: FIPS-197 vectors, start-while-busy, mid-stream reset and random keys
// checked cycle by cycle against a textbook key-expansion model.
module tb_okeysched;
  logic         clk = 1'b0, reset = 1'b0, start = 1'b0, dir = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] roundKey;
  logic         cstart, kvalid, done, busy;
  int           n_chk = 0, n_fail = 0;
  logic [127:0] rk [11];

  okeysched dut (.clk(clk), .reset(reset), .start(start), .dir(dir), .key(key),
                 .roundKey(roundKey), .cstart(cstart), .kvalid(kvalid), .done(done), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    logic         d;
    logic [127:0] k;
    logic [127:0] first;
    logic [127:0] second;
    logic [127:0] last;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      y = y >> 1;
      x = xt(x);
    end
    return p;
  endfunction

  // GF(2^8) inverse (x^254) followed by the AES affine transform
  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] y, r, s;
    y = 8'h01;
    for (int i = 0; i < 254; i++) y = gmul(y, x);
    if (x == 8'h00) y = 8'h00;
    r = y; s = y;
    for (int i = 0; i < 4; i++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  task automatic expand_key(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Entered just after a clock edge; returns in the first IDLE cycle with start low.
  task automatic run(input logic d, input logic [127:0] k, input bit tog,
                     output logic [127:0] first, output logic [127:0] second, output logic [127:0] last);
    int n;
    logic e_cs, e_kv, e_dn, e_bz, rk_chk;
    logic [127:0] e_rk;
    expand_key(k);
    n = d ? 22 : 13;
    first = '0; second = '0; last = '0;
    start = 1'b1; dir = d; key = k;
    @(posedge clk); #1;
    for (int c = 1; c <= n; c++) begin
      if (!d) begin
        e_bz = c < 13; e_cs = c == 1; e_kv = c >= 2 && c <= 12; e_dn = c == 12; rk_chk = 1'b1;
        e_rk = c == 1 ? k : (c <= 12 ? rk[c-2] : rk[10]);
      end else begin
        e_bz = c < 22; e_cs = c == 11; e_kv = c >= 11 && c <= 21; e_dn = c == 21; rk_chk = c >= 11;
        e_rk = c <= 21 ? rk[(21-c) % 11] : rk[0];
      end
      chk($sformatf("ctrl{cs,kv,dn,bz} dir=%0d T+%0d", d, c), {124'h0, cstart, kvalid, done, busy},
          {124'h0, e_cs, e_kv, e_dn, e_bz});
      if (rk_chk) chk($sformatf("roundKey dir=%0d T+%0d", d, c), roundKey, e_rk);
      if (c == (d ? 11 : 2)) first = roundKey;
      if (c == (d ? 12 : 3)) second = roundKey;
      if (c == (d ? 21 : 12)) last = roundKey;
      if (tog && c < n) begin
        start = 1'b1; dir = 1'($urandom);
        key = {$urandom, $urandom, $urandom, $urandom};
      end else start = 1'b0;
      if (c < n) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    vec_t tbl [4];
    logic [127:0] f, s, l, rkey;
    logic rd;
    tbl[0] = '{1'b0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h2b7e151628aed2a6abf7158809cf4f3c,
               128'ha0fafe1788542cb123a339392a6c7605, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    tbl[1] = '{1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
               128'hac7766f319fadc2128d12941575c006e, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    tbl[2] = '{1'b0, 128'h000102030405060708090a0b0c0d0e0f, 128'h000102030405060708090a0b0c0d0e0f,
               128'h0, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    tbl[3] = '{1'b1, 128'h000102030405060708090a0b0c0d0e0f, 128'h13111d7fe3944a17f307a78b4d2b30c5,
               128'h0, 128'h000102030405060708090a0b0c0d0e0f};
    start = 1'b1; dir = 1'b1; key = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset roundKey", roundKey, 128'h0);
    chk("reset ctrl", {124'h0, cstart, kvalid, done, busy}, 128'h0);
    start = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("idle after reset", {127'h0, busy}, 128'h0);
    for (int i = 0; i < 4; i++) begin
      run(tbl[i].d, tbl[i].k, 1'b0, f, s, l);
      chk($sformatf("vec%0d first key", i), f, tbl[i].first);
      if (tbl[i].second != 128'h0) chk($sformatf("vec%0d second key", i), s, tbl[i].second);
      chk($sformatf("vec%0d last key", i), l, tbl[i].last);
    end
    run(1'b1, tbl[1].k, 1'b1, f, s, l);
    chk("toggled decrypt last", l, tbl[1].k);
    run(1'b0, tbl[2].k, 1'b1, f, s, l);
    chk("toggled encrypt last", l, tbl[2].last);
    run(1'b0, tbl[0].k, 1'b0, f, s, l);
    chk("accept on first idle", l, tbl[0].last);
    start = 1'b1; dir = 1'b1; key = tbl[0].k;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async reset roundKey", roundKey, 128'h0);
    chk("async reset ctrl", {124'h0, cstart, kvalid, done, busy}, 128'h0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    run(1'b0, tbl[0].k, 1'b0, f, s, l);
    chk("post-reset encrypt last", l, tbl[0].last);
    for (int i = 0; i < 6; i++) begin
      rd = 1'($urandom);
      rkey = {$urandom, $urandom, $urandom, $urandom};
      run(rd, rkey, 1'($urandom), f, s, l);
      chk($sformatf("random%0d last", i), l, rd ? rkey : rk[10]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/okeysched.md
Name: okeysched

Overview:
- AES-128 round-key producer. It is the source end of the roundKey/done interface that the one-round-per-cycle cipher engine consumes.
- Keys are streamed one per cycle, with the timing the engine expects:
  - Encrypt (dir=0): forward order, rk0..rk10.
  - Decrypt (dir=1): reverse order, rk10..rk0.
- It generates the engine's restart pulse (cstart) and the done flag.
- Decrypt runs in two phases: 10 forward expansion cycles reach rk10, then the inverse key schedule steps backward. No 11-entry key store is used.

Parameters:
- None. AES-128 only (Nk=4, 10 rounds), fixed.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request a new key stream; accepted only in IDLE.
- dir  in  1  0 = encrypt order, 1 = decrypt order; sampled on accept.
- key  in  128  cipher key; byte 0 in [127:120]; registered on accept.
- roundKey  out  128  current round key to the cipher.
- cstart  out  1  one-cycle pulse; drive the cipher's reset with it.
- kvalid  out  1  high while roundKey is a live stream key.
- done  out  1  one-cycle pulse coincident with the final round key.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE, every output 0, round counter 0, key register 0.
- States: IDLE, PRIME, EXPAND, STREAM.
- IDLE:
  - start=1 registers key and dir, then goes to PRIME (dir=0) or EXPAND (dir=1).
  - start=0: stay in IDLE.
- Accept cycle is T.
- Encrypt:
  - T+1 PRIME: cstart=1, kvalid=0, roundKey=key.
  - T+2 STREAM: roundKey=rk0=key, kvalid=1.
  - T+3..T+11: rk1..rk9.
  - T+12: rk10 with done=1.
  - T+13: IDLE.
- Decrypt:
  - T+1..T+10 EXPAND: internal register advances rk0 to rk10 one round per cycle; kvalid=0, cstart=0.
  - T+11 (first STREAM cycle): cstart=1, kvalid=1, roundKey=rk10.
  - T+12..T+20: rk9..rk1.
  - T+21: rk0 with done=1.
  - T+22: IDLE.
- Forward step, with words w0..w3 of rk(i-1) and w0 = key[127:96]:
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon[i],24'h0}
  - w1' = w1 ^ w0'
  - w2' = w2 ^ w1'
  - w3' = w3 ^ w2'
- Inverse step, from rk(i) to rk(i-1):
  - w3p = w3 ^ w2, w2p = w2 ^ w1, w1p = w1 ^ w0
  - w0p = w0 ^ SubWord(RotWord(w3p)) ^ {Rcon[i],24'h0}
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. The 4-bit round counter indexes Rcon.
  - Counter counts up in EXPAND and encrypt STREAM.
  - Counter counts down in decrypt STREAM.
- One forward S-box instance of 4 bytes is shared by both step directions. The S-box function is identical to the cipher's forward S-box.
- roundKey and kvalid/done/cstart are registered outputs; no combinational path from start.
- Output holds:
  - After done, roundKey holds the final key until the next accepted start.
  - kvalid, cstart and done are 0 in IDLE.
- start while busy is ignored, including start in the done cycle. A start in the following IDLE cycle is accepted.
- Changes to key or dir after accept have no effect on the stream in progress.
- reset asserted mid-stream: immediate return to IDLE with all outputs 0. No partial done is produced.
- Consumer contract: the cipher samples roundKey every cycle after cstart with no stall. This block never pauses a stream.

Test Plan:
- Encrypt, FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, start at T:
  - cstart at T+1.
  - roundKey=key at T+2.
  - a0fafe1788542cb123a339392a6c7605 at T+3.
  - d014f9a8c9ee2589e13f0cc8b6630ca6 with done=1 at T+12.
  - busy=0 at T+13.
- Decrypt, same key:
  - busy=1 and kvalid=0 for T+1..T+10.
  - cstart=1 and roundKey=d014f9a8c9ee2589e13f0cc8b6630ca6 at T+11.
  - rk9 (ac7766f319fadc2128d12941575c006e) at T+12.
  - roundKey=key with done=1 at T+21.
- Decrypt, key 000102030405060708090a0b0c0d0e0f:
  - first streamed key = 13111d7fe3944a17f307a78b4d2b30c5.
  - last key = input key with done.
  - key sequence is the reverse of the encrypt run, checked key by key.
- start pulsed every cycle during a stream, with key/dir toggling: stream unchanged; next accept occurs on the first IDLE cycle.
- reset pulled low at T+7 of a decrypt: all outputs 0 asynchronously. After release, a fresh encrypt runs with correct T+12 timing.
- End-to-end: connect to the cipher engine (cstart drives the engine reset, done drives engine done). A.1 plaintext 3243f6a8885a308d313198a2e0370734 gives 3925841d02dc09fbdc118597196a0b32, and decrypt recovers the plaintext.
